lsu_load_store_unit: RTL and testbench
======================================

Name: lsu_load_store_unit

Overview:
Load/store unit in the MEM stage of the 32-bit RV32I pipeline. It sits directly upstream of the writeback select mux and produces the `rdata` operand that the mux picks when `wb_sel=2'b00`. It takes the ALU result as the effective address and runs a valid/grant/rvalid handshake with data memory. Bytes and halfwords are lane-steered and sign/zero-extended. The pipeline is stalled until the access completes.

Parameters:
- XLEN, 32, data/address width. Only 32 is supported.
- BE_W, 4, byte-enable width, equal to XLEN/8.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  memory instruction present in MEM stage
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective address (ALU output)
- req_wdata  in  32  store data (rs2)
- stall  out  1  freeze PC and pipeline registers
- rdata  out  32  formatted load data, to writeback mux
- rdata_valid  out  1  one-cycle pulse, load completed
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  word-aligned address, req_addr with [1:0] forced to 00
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  raw read word
- misalign  out  1  misaligned-access pulse; exists only with the macro

Behaviour:
- Reset: state IDLE. stall, rdata_valid, mem_req, mem_we, misalign = 0. rdata, mem_addr, mem_wdata = 0. mem_be = 0000.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid: register we, funct3, addr[1:0], formatted address, wdata and BE; go to REQ.
- REQ:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_gnt.
  - mem_gnt with a store: go to DONE.
  - mem_gnt with a load: go to WAIT.
  - mem_gnt and mem_rvalid may arrive in the same cycle. In that case a load captures the data and goes straight to DONE.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: format mem_rdata into the rdata register; go to DONE.
  - There is no timeout.
- DONE:
  - stall=0. rdata_valid=1 for loads, 0 for stores. Next state IDLE.
  - req_valid seen in DONE belongs to the completing instruction and is ignored.
- stall is 1 in REQ and WAIT.
- Minimum latency with gnt in REQ and rvalid the next cycle:
  - Load: 4 cycles (IDLE, REQ, WAIT, DONE), 3 stall cycles.
  - Store: 3 cycles, 2 stall cycles.
- Store steering:
  - SB: wdata[7:0] replicated to all 4 lanes; be = 0001 << addr[1:0].
  - SH: wdata[15:0] replicated to both halves; be = addr[1] ? 1100 : 0011.
  - SW: be = 1111.
- Load formatting:
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - B/H are sign-extended; BU/HU are zero-extended; W passes through.
- Unlisted funct3 values (011, 110, 111) are treated as W.
- Misalignment without the macro: SH/LH/LHU ignore addr[0]; SW/LW ignore addr[1:0]. No error is flagged.
- rdata holds the last load value until the next load completes. Stores never change it.
- mem_rvalid arriving in IDLE, REQ (without gnt) or DONE is ignored.
- Reset mid-operation: at the edge the FSM returns to IDLE and all outputs take their reset values. The outstanding memory transaction is abandoned, and a late rvalid is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1 or a word with addr[1:0]≠00 issues no mem_req. IDLE goes directly to DONE.
  - In DONE: misalign=1 for one cycle, rdata_valid=0, rdata unchanged.
  - The misalign port is present.
- Undefined: the misalign port is absent, and misaligned accesses are truncated as described under Behaviour.

Test Plan:
- Reset: assert rst for 2 cycles during WAIT of a load → next cycle all outputs are 0 and state is IDLE. A late mem_rvalid with 0xDEADBEEF leaves rdata at 0 and rdata_valid at 0.
- LW to addr 0x100, mem_rdata=0x12345678, gnt immediate, rvalid one cycle later:
  - mem_addr=0x100, be=1111.
  - stall high for 3 cycles.
  - rdata_valid pulse in cycle 4 with rdata=0x12345678.
- LB at addr 0x103 with mem_rdata=0x80FF0000 → rdata=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF. LHU → 0x000080FF.
- SB at addr 0x201 with wdata=0x000000AB → mem_addr=0x200, mem_wdata=0xABABABAB, be=0010. mem_gnt held low 3 cycles then high → request fields stable throughout, then DONE, no rdata_valid, rdata unchanged.
- Load with mem_gnt and mem_rvalid in the same cycle → WAIT is skipped and DONE follows with correct data. Back-to-back loads: the second req_valid is accepted in the IDLE cycle after DONE.
- With LSU_MISALIGN_TRAP_EN, LW at 0x102 → mem_req never asserts, misalign pulses for 1 cycle, rdata unchanged. Without the macro: mem_addr=0x100, be=1111.

Source files
------------

// File: rtl/lsu_load_store_unit.sv
// MEM-stage load/store unit: valid/grant/rvalid handshake to data memory, lane steering and load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN adds the misalign port and suppresses misaligned requests.
module lsu_load_store_unit #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   rdata_q;
  logic              accept;
  logic              ld_capture;
  logic              mis_now;
  logic              mis_q;

  // funct3[1:0] encodes the width: 00 byte, 01 half, anything else is a word
  function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] w);
    case (f3[1:0])
      2'b00:   store_data = {4{w[7:0]}};
      2'b01:   store_data = {2{w[15:0]}};
      default: store_data = w;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b100:  load_fmt = {24'd0, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b101:  load_fmt = {16'd0, h};
      default: load_fmt = w;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_now = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   (req_funct3[1] && (req_addr[1:0] != 2'b00));
`else
  assign mis_now = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    ld_capture = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_d = mis_now ? DONE : REQ;
      end
      REQ: if (mem_gnt) begin
        ld_capture = !we_q && mem_rvalid;
        state_d    = (we_q || mem_rvalid) ? DONE : WAIT;
      end
      WAIT: if (mem_rvalid) begin
        ld_capture = 1'b1;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rdata_valid = 1'b0;
    case (state_q)
      IDLE: stall = req_valid;
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
      end
      WAIT: stall = 1'b1;
      default: rdata_valid = !we_q && !mis_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        addr_q   <= {req_addr[XLEN-1:2], 2'b00};
        wdata_q  <= store_data(req_funct3, req_wdata);
        be_q     <= store_be(req_funct3, req_addr[1:0]);
        mis_q    <= mis_now;
      end
      if (ld_capture) rdata_q <= load_fmt(funct3_q, off_q, mem_rdata);
    end
  end

  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = (state_q == DONE) && mis_q;
`endif

endmodule

// File: tb/tb_lsu_load_store_unit.sv
// Bench for lsu_load_store_unit: vector table driven through a memory responder, load results scoreboarded.
module tb_lsu_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  lsu_load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    int          gnt_dly;
    int          rv_dly;
    bit          same;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] mrd, input logic [31:0] exp_rdata,
                     input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                     input logic [3:0] exp_be, input int gnt_dly, input int rv_dly, input bit same);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrd = mrd;
    v.exp_rdata = exp_rdata; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    v.exp_be = exp_be; v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.same = same;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Load completions are matched in order against what the stimulus predicted
  always @(negedge clk) begin
    if (!rst && rdata_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rdata_valid", 32'(rdata_valid), 32'd0);
      else chk("load_rdata", rdata, exp_q.pop_front());
    end
  end

  task automatic run_op(input vec_t v);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    #1;
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    if (!v.we) begin
      exp_q.push_back(v.exp_rdata);
      last_rdata = v.exp_rdata;
    end
    step();
    for (int i = 0; i <= v.gnt_dly; i++) begin
      mem_gnt = (i == v.gnt_dly);
      if (!mem_gnt) begin
        mem_rvalid = 1'b1;  // stray rvalid before the grant must be ignored
        mem_rdata  = 32'hFFFF_FFFF;
      end else if (!v.we && v.same) begin
        mem_rvalid = 1'b1;
        mem_rdata  = v.mrd;
      end else begin
        mem_rvalid = 1'b0;
      end
      #1;
      chk("req_mem_req", 32'(mem_req), 32'd1);
      chk("req_mem_we", 32'(mem_we), 32'(v.we));
      chk("req_mem_addr", mem_addr, v.exp_addr);
      chk("req_mem_wdata", mem_wdata, v.exp_wdata);
      chk("req_mem_be", 32'(mem_be), 32'(v.exp_be));
      chk("req_stall", 32'(stall), 32'd1);
      step();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    if (!v.we && !v.same) begin
      for (int i = 0; i <= v.rv_dly; i++) begin
        mem_rvalid = (i == v.rv_dly);
        mem_rdata  = mem_rvalid ? v.mrd : 32'h0BAD_0BAD;
        #1;
        chk("wait_mem_req", 32'(mem_req), 32'd0);
        chk("wait_stall", 32'(stall), 32'd1);
        step();
      end
      mem_rvalid = 1'b0;
    end
    #1;
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_rdata_valid", 32'(rdata_valid), 32'(!v.we));
    chk("done_mem_req", 32'(mem_req), 32'd0);
    if (v.we) chk("store_rdata_hold", rdata, last_rdata);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010; req_addr = '0;
    req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; last_rdata = '0;
    step(); step();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    rst = 1'b0;

    // Reset while a load waits for rvalid; a late rvalid must be dropped
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; req_valid = 1'b0;
    #1 chk("pre_rst_wait_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_be", 32'(mem_be), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("late_rvalid_rdata", rdata, 32'd0);
    chk("late_rvalid_valid", 32'(rdata_valid), 32'd0);
    chk("late_rvalid_stall", 32'(stall), 32'd0);
    step();
    chk("late_rvalid_rdata2", rdata, 32'd0);

    //  we   f3      addr          wdata         mrd           exp_rdata     exp_addr      exp_wdata    be    g  r  same
    add(1'b0, 3'b010, 32'h100, 32'h0,         32'h1234_5678, 32'h1234_5678, 32'h100, 32'h0,         4'hF, 0, 0, 0);
    add(1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF_0000, 32'hFFFF_FF80, 32'h100, 32'h0,         4'h8, 0, 0, 1);
    add(1'b0, 3'b100, 32'h103, 32'h0,         32'h80FF_0000, 32'h0000_0080, 32'h100, 32'h0,         4'h8, 2, 2, 0);
    add(1'b0, 3'b001, 32'h102, 32'h0,         32'h80FF_0000, 32'hFFFF_80FF, 32'h100, 32'h0,         4'hC, 0, 1, 0);
    add(1'b0, 3'b101, 32'h102, 32'h0,         32'h80FF_0000, 32'h0000_80FF, 32'h100, 32'h0,         4'hC, 0, 0, 0);
    add(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0,         32'h0,         32'h200, 32'hABAB_ABAB, 4'h2, 3, 0, 0);
    add(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0,         32'h0,         32'h200, 32'hBEEF_BEEF, 4'hC, 0, 0, 0);
    add(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0,         32'h0,         32'h300, 32'hCAFE_F00D, 4'hF, 1, 0, 0);
    add(1'b0, 3'b000, 32'h101, 32'h0,         32'h0000_7F00, 32'h0000_007F, 32'h100, 32'h0,         4'h2, 0, 0, 0);
    add(1'b0, 3'b011, 32'h104, 32'h0,         32'h89AB_CDEF, 32'h89AB_CDEF, 32'h104, 32'h0,         4'hF, 0, 0, 1);
    add(1'b0, 3'b001, 32'h200, 32'h0,         32'h1234_8001, 32'hFFFF_8001, 32'h200, 32'h0,         4'h3, 0, 0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    add(1'b0, 3'b010, 32'h102, 32'h0,         32'h55AA_55AA, 32'h55AA_55AA, 32'h100, 32'h0,         4'hF, 0, 0, 0);
    add(1'b0, 3'b001, 32'h101, 32'h0,         32'h8001_7FFF, 32'h0000_7FFF, 32'h100, 32'h0,         4'h3, 0, 0, 0);
`endif

    // Entries run back to back: each new request arrives in the IDLE right after DONE
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

`ifdef LSU_MISALIGN_TRAP_EN
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102;
    #1 chk("mis_idle_stall", 32'(stall), 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    chk("mis_mem_req", 32'(mem_req), 32'd0);
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("mis_rdata", rdata, last_rdata);
    step();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    chk("mis_after_mem_req", 32'(mem_req), 32'd0);
    chk("mis_after_rdata", rdata, last_rdata);
`endif

    step();
    chk("idle_after_all", 32'(mem_req), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
